// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port memory access controller with single-beat writes
// and incrementing read bursts, one outstanding host request at a time.
`default_nettype none

module mem_access_ctrl #(
  parameter int AddrSize = 8,
  parameter int DataSize = 32,
  parameter int LenSize  = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic                ReqRW,
  input  logic [AddrSize-1:0] ReqAddr,
  input  logic [DataSize-1:0] ReqData,
  input  logic [LenSize-1:0]  ReqLen,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [DataSize-1:0] RspData,
  output logic                RspLast,
  output logic                WrAck,
  output logic                MemValid,
  output logic                MemRW,
  output logic [AddrSize-1:0] MemAddr,
  output logic [DataSize-1:0] MemDin,
  input  logic [DataSize-1:0] MemDout
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]          state;
  logic [LenSize-1:0]  beats_left;
  logic [DataSize-1:0] rsp_data;
  logic                wr_ack;
  logic                mem_rw;
  logic [AddrSize-1:0] mem_addr;
  logic [DataSize-1:0] mem_din;
  logic                accept;

  // The WrAck cycle is spent in IDLE but must not overlap ReqReady.
  assign ReqReady = (state == IDLE) && !wr_ack;
  assign accept   = ReqValid && ReqReady;

  assign MemValid = (state == WRITE) || (state == ISSUE);
  assign RspValid = (state == RESP);
  assign RspLast  = (state == RESP) && (beats_left == '0);
  assign RspData  = rsp_data;
  assign WrAck    = wr_ack;
  assign MemRW    = mem_rw;
  assign MemAddr  = mem_addr;
  assign MemDin   = mem_din;

  // mem_addr doubles as the burst's current address register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      beats_left <= '0;
      rsp_data   <= '0;
      wr_ack     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_rw   <= ReqRW;
            mem_addr <= ReqAddr;
            mem_din  <= ReqData;
            if (ReqRW) begin
              state <= WRITE;
            end else begin
              beats_left <= ReqLen;
              state      <= ISSUE;
            end
          end
        end
        WRITE: begin
          wr_ack <= 1'b1;
          state  <= IDLE;
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data <= MemDout;
          state    <= RESP;
        end
        RESP: begin
          if (RspReady) begin
            if (beats_left == '0) begin
              state <= IDLE;
            end else begin
              beats_left <= beats_left - 1'b1;
              mem_addr   <= mem_addr + 1'b1;
              state      <= ISSUE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized transactions against a
// transaction-level memory reference model.
`default_nettype none

module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqRW;
  logic [7:0]  ReqAddr;
  logic [31:0] ReqData;
  logic [3:0]  ReqLen;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic        RspLast;
  logic        WrAck;
  logic        MemValid;
  logic        MemRW;
  logic [7:0]  MemAddr;
  logic [31:0] MemDin;
  logic [31:0] MemDout;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;

  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  logic [31:0] mem_dout = 32'h0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.AddrSize(8), .DataSize(32), .LenSize(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqRW(ReqRW),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqLen(ReqLen),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspLast(RspLast),
    .WrAck(WrAck),
    .MemValid(MemValid), .MemRW(MemRW), .MemAddr(MemAddr), .MemDin(MemDin),
    .MemDout(MemDout)
  );

  // Memory with registered read data
  assign MemDout = mem_dout;
  always @(posedge Clk) begin
    if (MemValid) begin
      if (MemRW) mem_arr[MemAddr] <= MemDin;
      else       mem_dout <= mem_arr[MemAddr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) if (Reset && ReqValid && ReqReady) accepts++;

  always @(negedge Clk) begin
    if (Reset === 1'b1)
      check("exclusive", 64'(ReqReady && (RspValid || WrAck || MemValid)), 64'd0);
  end

  task automatic scramble();
    ReqValid = 1'b0;
    ReqRW    = 1'($urandom);
    ReqAddr  = 8'($urandom);
    ReqData  = $urandom;
    ReqLen   = 4'($urandom);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ReqReady && n < 60) begin
      @(negedge Clk);
      n++;
    end
    check("ready_wait", 64'(ReqReady), 64'd1);
  endtask

  // All transaction tasks start and end at a falling edge.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    ReqValid = 1'b1; ReqRW = 1'b1; ReqAddr = a; ReqData = d; ReqLen = 4'($urandom);
    wait_ready();
    @(posedge Clk); @(negedge Clk);
    scramble();
    check("wr_memvalid", 64'(MemValid), 64'd1);
    check("wr_memrw", 64'(MemRW), 64'd1);
    check("wr_addr", 64'(MemAddr), 64'(a));
    check("wr_din", 64'(MemDin), 64'(d));
    check("wr_ack_early", 64'(WrAck), 64'd0);
    @(negedge Clk);
    check("wr_memvalid_off", 64'(MemValid), 64'd0);
    check("wr_ack", 64'(WrAck), 64'd1);
    check("wr_ready_busy", 64'(ReqReady), 64'd0);
    @(negedge Clk);
    check("wr_ack_off", 64'(WrAck), 64'd0);
    check("wr_ready", 64'(ReqReady), 64'd1);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] len,
                         input int stall_beat, input int stall_cycles,
                         input bit hold, input logic [7:0] h_addr, input logic [31:0] h_data);
    logic [7:0]  ea;
    logic [31:0] held_data;
    logic        held_last;
    ReqValid = 1'b1; ReqRW = 1'b0; ReqAddr = a; ReqLen = len; ReqData = $urandom;
    wait_ready();
    @(posedge Clk); @(negedge Clk);
    if (hold) begin
      ReqRW = 1'b1; ReqAddr = h_addr; ReqData = h_data; ReqLen = 4'($urandom);
    end else begin
      scramble();
    end
    for (int i = 0; i <= int'(len); i++) begin
      ea = a + 8'(i);
      check("rd_issue_mv", 64'(MemValid), 64'd1);
      check("rd_issue_rw", 64'(MemRW), 64'd0);
      check("rd_issue_addr", 64'(MemAddr), 64'(ea));
      check("rd_issue_rv", 64'(RspValid), 64'd0);
      @(negedge Clk);
      check("rd_cap_mv", 64'(MemValid), 64'd0);
      check("rd_cap_rv", 64'(RspValid), 64'd0);
      @(negedge Clk);
      check("rd_rv", 64'(RspValid), 64'd1);
      check("rd_data", 64'(RspData), 64'(ref_mem[ea]));
      check("rd_last", 64'(RspLast), 64'(i == int'(len)));
      check("rd_rsp_mv", 64'(MemValid), 64'd0);
      held_data = ref_mem[ea];
      held_last = (i == int'(len));
      if (i == stall_beat) begin
        for (int k = 0; k < stall_cycles; k++) begin
          RspReady = 1'b0;
          @(negedge Clk);
          check("stall_rv", 64'(RspValid), 64'd1);
          check("stall_data", 64'(RspData), 64'(held_data));
          check("stall_last", 64'(RspLast), 64'(held_last));
          check("stall_mv", 64'(MemValid), 64'd0);
        end
      end
      RspReady = 1'b1;
      @(posedge Clk); @(negedge Clk);
      RspReady = 1'b0;
    end
    check("rd_end_rv", 64'(RspValid), 64'd0);
    if (!hold) check("rd_end_ready", 64'(ReqReady), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [31:0] v;
    Reset = 1'b0;
    RspReady = 1'b0;
    scramble();
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    #3;
    check("rst_ready", 64'(ReqReady), 64'd1);
    check("rst_rspvalid", 64'(RspValid), 64'd0);
    check("rst_memvalid", 64'(MemValid), 64'd0);
    check("rst_wrack", 64'(WrAck), 64'd0);
    check("rst_memaddr", 64'(MemAddr), 64'd0);
    check("rst_memdin", 64'(MemDin), 64'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    // First edge after release must already accept.
    a0 = accepts;
    do_write(8'h10, 32'hDEADBEEF);
    check("first_accept", 64'(accepts - a0), 64'd1);
    do_read(8'h10, 4'd0, -1, 0, 1'b0, 8'h0, 32'h0);
    do_read(8'hFE, 4'd3, -1, 0, 1'b0, 8'h0, 32'h0);
    do_read(8'h33, 4'd3, 1, 5, 1'b0, 8'h0, 32'h0);
    do_read(8'hF8, 4'd15, 7, 2, 1'b0, 8'h0, 32'h0);

    // Reset during CAPTURE of a four-beat burst
    ReqValid = 1'b1; ReqRW = 1'b0; ReqAddr = 8'h40; ReqLen = 4'd3;
    wait_ready();
    @(posedge Clk); @(negedge Clk);
    scramble();
    @(negedge Clk);
    check("mid_cap_mv", 64'(MemValid), 64'd0);
    #2 Reset = 1'b0;
    #1;
    check("arst_ready", 64'(ReqReady), 64'd1);
    check("arst_rspvalid", 64'(RspValid), 64'd0);
    check("arst_rsplast", 64'(RspLast), 64'd0);
    check("arst_wrack", 64'(WrAck), 64'd0);
    check("arst_memvalid", 64'(MemValid), 64'd0);
    check("arst_memrw", 64'(MemRW), 64'd0);
    check("arst_memaddr", 64'(MemAddr), 64'd0);
    check("arst_memdin", 64'(MemDin), 64'd0);
    check("arst_rspdata", 64'(RspData), 64'd0);
    repeat (3) begin
      @(negedge Clk);
      check("inrst_mv", 64'(MemValid), 64'd0);
      check("inrst_rv", 64'(RspValid), 64'd0);
    end
    Reset = 1'b1;
    do_write(8'h20, 32'h12345678);
    do_read(8'h20, 4'd0, -1, 0, 1'b0, 8'h0, 32'h0);

    // Request held high through a burst: accepted once, only in IDLE
    a0 = accepts;
    do_read(8'h50, 4'd2, 1, 3, 1'b1, 8'h60, 32'hCAFEF00D);
    check("hold_one_accept", 64'(accepts - a0), 64'd1);
    do_write(8'h60, 32'hCAFEF00D);
    check("hold_second_accept", 64'(accepts - a0), 64'd2);
    do_read(8'h60, 4'd0, -1, 0, 1'b0, 8'h0, 32'h0);

    for (int t = 0; t < 24; t++) begin
      logic [3:0] l;
      if ($urandom_range(0, 1) == 1) begin
        do_write(8'($urandom), $urandom);
      end else begin
        l = 4'($urandom);
        do_read(8'($urandom), l, int'($urandom_range(0, int'(l))),
                int'($urandom_range(0, 3)), 1'b0, 8'h0, 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
 - AddrSize  8   memory address width
 - DataSize  32  data word width
 - LenSize   4   burst-length field width
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
 - Clk        in   1          sole clock, rising edge
 - Reset      in   1          asynchronous, active-low reset
 - ReqValid   in   1          host request valid
 - ReqReady   out  1          controller can accept a request
 - ReqRW      in   1          1 = write, 0 = read
 - ReqAddr    in   AddrSize   start address
 - ReqData    in   DataSize   write data, single beat
 - ReqLen     in   LenSize    read burst length minus 1; ignored for writes
 - RspValid   out  1          read data valid
 - RspReady   in   1          host accepts read data
 - RspData    out  DataSize   read data word
 - RspLast    out  1          final word of a read burst
 - WrAck      out  1          one-cycle pulse when a write completes
 - MemValid   out  1          memory access strobe
 - MemRW      out  1          1 = write, 0 = read, to memory
 - MemAddr    out  AddrSize   memory address
 - MemDin     out  DataSize   memory write data
 - MemDout    in   DataSize   memory registered read data

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, WRITE, ISSUE, CAPTURE, RESP.
REQ-004 ReqReady SHALL be 1 only in IDLE. A request is accepted on a rising edge with ReqValid=1 and ReqReady=1.
REQ-005 On acceptance, ReqRW, ReqAddr, ReqData and ReqLen SHALL be latched into internal registers. Later request-input changes SHALL have no effect until the next acceptance.
REQ-006 On acceptance of a write, the FSM SHALL go IDLE->WRITE. In WRITE, the outputs SHALL be MemValid=1, MemRW=1, MemAddr = latched address, MemDin = latched data.
REQ-007 From WRITE, the FSM SHALL return to IDLE on the next edge and SHALL assert WrAck for the following single cycle.
REQ-008 On acceptance of a read, the FSM SHALL load the remaining-beat counter with ReqLen and SHALL go IDLE->ISSUE.
REQ-009 In ISSUE, the outputs SHALL be MemValid=1, MemRW=0, MemAddr = current address. The FSM SHALL go to CAPTURE on the next edge.
REQ-010 In CAPTURE, MemValid SHALL be 0. On the edge leaving CAPTURE, RspData SHALL be loaded from MemDout, and the FSM SHALL go to RESP.
REQ-011 In RESP, RspValid SHALL be 1, and RspData and RspLast SHALL stay stable until the edge where RspReady=1.
REQ-012 RspLast SHALL be 1 exactly when the remaining-beat counter equals 0.
REQ-013 On the RESP handshake edge:
 - if the counter is 0, the FSM SHALL go to IDLE;
 - otherwise the counter SHALL decrement, the address SHALL increment modulo 2**AddrSize (0xFF wraps to 0x00 at AddrSize=8), and the FSM SHALL go to ISSUE.
REQ-014 First-word read latency SHALL be 3 cycles: RspValid rises after the third edge following acceptance. Each later beat SHALL take 3 cycles after the previous handshake.
REQ-015 Outside WRITE and ISSUE, MemValid SHALL be 0. MemRW, MemAddr and MemDin SHALL hold their last latched values.
REQ-016 No new request SHALL be accepted while a write or read burst is in progress. A request asserted in any non-IDLE state SHALL wait, not be dropped.
REQ-017 A burst length of ReqLen=0 SHALL yield exactly one response, with RspLast=1. ReqLen at its maximum value SHALL yield 2**LenSize responses.
REQ-018 RspValid, WrAck and MemValid SHALL never be 1 in the same cycle as ReqReady=1.

Reset
REQ-019 Reset=0 SHALL immediately, without waiting for Clk, force the following:
 - state = IDLE;
 - ReqReady = 1;
 - RspValid, RspLast, WrAck, MemValid, MemRW = 0;
 - RspData, MemAddr, MemDin and all internal registers = 0.
REQ-020 Reset asserted mid-burst or mid-write SHALL abandon the operation, with no further MemValid or RspValid. After deassertion the block SHALL accept requests normally.
REQ-021 Reset SHALL be released synchronously to operation: the first request is accepted on the first rising edge with Reset=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
 - Write ReqAddr=0x10, ReqData=0xDEADBEEF -> one cycle of MemValid=1, MemRW=1, MemAddr=0x10, MemDin=0xDEADBEEF, then a one-cycle WrAck, then ReqReady=1.
 - Read ReqAddr=0x10, ReqLen=0, with the memory model holding 0xDEADBEEF -> RspValid after 3 cycles, RspData=0xDEADBEEF, RspLast=1.
 - Read ReqAddr=0xFE, ReqLen=3 -> MemAddr sequence 0xFE, 0xFF, 0x00, 0x01, four responses, RspLast only on the fourth.
 - Read burst with RspReady held 0 for 5 cycles on beat 2 -> RspData/RspLast stable throughout, no MemValid during the stall, the next ISSUE only after the handshake.
 - Reset=0 during CAPTURE of a 4-beat burst -> all outputs at reset values asynchronously; after release a write to 0x20 completes normally.
 - ReqValid held high through a read burst -> the second request is accepted only in IDLE, exactly once.
